// File: rtl/mfp_ahb_lite_master.sv
// AHB-Lite initiator: converts a valid/ready request stream into single NONSEQ
// transfers with pipelined address/data phases and in-order responses.
`timescale 1ns/1ps
module mfp_ahb_lite_master #(
  parameter logic [3:0] HPROT_VALUE = 4'b0011,
  parameter bit         ALIGN_CHECK = 1'b1
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_write,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic [31:0] HADDR,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic        HMASTLOCK,
  output logic [3:0]  HPROT,
  output logic [1:0]  HTRANS,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  function automatic logic is_misaligned(input logic [1:0] lsb, input logic [2:0] size);
    case (size)
      3'd0:    return 1'b0;
      3'd1:    return lsb[0];
      3'd2:    return lsb != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

  logic        addr_pend;
  logic        data_pend;
  logic        data_write_p1;
  logic [31:0] wdata_p0;
  logic        misaligned;
  logic        align_block;
  logic        accept_bus;
  logic        accept_local;

  assign misaligned   = ALIGN_CHECK && is_misaligned(req_addr[1:0], req_size);
  assign busy         = addr_pend || data_pend;
  // A misaligned request may only be answered locally once the bus drains,
  // otherwise its response would overtake earlier transfers.
  assign align_block  = misaligned && busy;
  assign req_ready    = (!addr_pend || HREADY) && !align_block;
  assign accept_bus   = req_valid && req_ready && !misaligned;
  assign accept_local = req_valid && req_ready && misaligned;

  assign HBURST    = 3'b000;
  assign HMASTLOCK = 1'b0;
  assign HPROT     = HPROT_VALUE;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_pend     <= 1'b0;
      data_pend     <= 1'b0;
      data_write_p1 <= 1'b0;
      wdata_p0      <= 32'h0;
      HADDR         <= 32'h0;
      HWRITE        <= 1'b0;
      HSIZE         <= 3'd0;
      HTRANS        <= HTRANS_IDLE;
      HWDATA        <= 32'h0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= 32'h0;
      rsp_err       <= 1'b0;
    end else begin
      // response stage: data phase retiring or local alignment reject
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
      if (data_pend && HREADY) begin
        rsp_valid <= 1'b1;
        rsp_err   <= HRESP;
        rsp_rdata <= (!data_write_p1 && !HRESP) ? HRDATA : 32'h0;
      end else if (accept_local) begin
        rsp_valid <= 1'b1;
        rsp_err   <= 1'b1;
      end

      // data phase stage: address slot moves down whenever HREADY is high
      if (HREADY) begin
        data_pend <= addr_pend;
        if (addr_pend) begin
          data_write_p1 <= HWRITE;
          HWDATA        <= wdata_p0;
        end
      end

      // address phase stage: a new request may replace the retiring one
      if (accept_bus) begin
        addr_pend <= 1'b1;
        HTRANS    <= HTRANS_NONSEQ;
        HADDR     <= req_addr;
        HWRITE    <= req_write;
        HSIZE     <= req_size;
        wdata_p0  <= req_write ? req_wdata : 32'h0;
      end else if (addr_pend && HREADY) begin
        addr_pend <= 1'b0;
        HTRANS    <= HTRANS_IDLE;
      end
    end
  end

endmodule
